// File: rtl/stim_player.sv
// ----------------------------------------------------------------------------
// StimPlayer -- pattern-memory stimulus player
//
// Holds a small pattern memory that can be written at any time and plays its
// entries out, one per clock, as a stimulus stream. Three playback modes:
//   ONESHOT (mode 00, also 11) : play entries 0..last once, then pulse done.
//   LOOP    (mode 01)          : replay 0..last forever, counting passes.
//   STEP    (mode 10)          : advance one entry per cycle with step=1.
//
// Ports
//   clock      : single clock, all state changes on the rising edge
//   reset      : asynchronous active-low reset (memory contents survive it)
//   wr_en      : pattern-memory write strobe
//   wr_addr    : pattern-memory write address
//   wr_data    : pattern-memory write data
//   start      : begin playback from IDLE (level tolerated)
//   stop       : abort playback; also blocks a start in the same cycle
//   mode       : playback mode, captured on the accepted start
//   last_addr  : index of the final entry, captured and clamped on start
//   step       : advance request, only meaningful in STEP mode
//   stim       : current stimulus word
//   stim_valid : stim holds an entry that is being played
//   pc         : index of the entry currently on stim
//   wrap_cnt   : completed LOOP passes, saturating at 255
//   done       : one-cycle pulse when playback completes normally
//   busy       : high whenever the player is not IDLE
// ----------------------------------------------------------------------------
module stim_player #(
    parameter  int DATA_W = 2,
    parameter  int DEPTH  = 16,
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [AW-1:0]     last_addr,
    input  logic              step,
    output logic [DATA_W-1:0] stim,
    output logic              stim_valid,
    output logic [AW-1:0]     pc,
    output logic [7:0]        wrap_cnt,
    output logic              done,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PLAY      = 2'd1,
        STEP_WAIT = 2'd2
    } state_t;

    localparam logic [1:0]    MODE_LOOP = 2'b01;
    localparam logic [1:0]    MODE_STEP = 2'b10;
    localparam logic [AW-1:0] MAX_ADDR  = AW'(DEPTH - 1);

    // Pattern memory; deliberately left out of the reset domain.
    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [DATA_W-1:0] stim_q, stim_d;
    logic              valid_q, valid_d;
    logic [AW-1:0]     pc_q, pc_d;
    logic [7:0]        wrap_q, wrap_d;
    logic              done_q, done_d;
    logic              loopMode_q, loopMode_d;
    logic [AW-1:0]     last_q, last_d;

    logic [AW-1:0]     pcNext;
    logic [AW-1:0]     lastClamped;

    assign pcNext = pc_q + AW'(1);

    // An out-of-range final index is pulled back to the top entry so the
    // player never fetches past the end of the memory.
    assign lastClamped = (last_addr > MAX_ADDR) ? MAX_ADDR : last_addr;

    // Memory writes land on the clock edge with non-blocking semantics, so a
    // fetch of the same address on the same edge still sees the old word.
    always_ff @(posedge clock) begin
        if (wr_en && (int'(wr_addr) < DEPTH)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            stim_q     <= '0;
            valid_q    <= 1'b0;
            pc_q       <= '0;
            wrap_q     <= '0;
            done_q     <= 1'b0;
            loopMode_q <= 1'b0;
            last_q     <= '0;
        end else begin
            state_q    <= state_d;
            stim_q     <= stim_d;
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            wrap_q     <= wrap_d;
            done_q     <= done_d;
            loopMode_q <= loopMode_d;
            last_q     <= last_d;
        end
    end

    // Next-state logic. Everything holds by default; done is a pulse and
    // therefore defaults low. stop always wins over start, step and the
    // normal end of playback, and an abort never produces a done pulse.
    always_comb begin
        state_d    = state_q;
        stim_d     = stim_q;
        valid_d    = valid_q;
        pc_d       = pc_q;
        wrap_d     = wrap_q;
        done_d     = 1'b0;
        loopMode_d = loopMode_q;
        last_d     = last_q;

        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    loopMode_d = (mode == MODE_LOOP);
                    last_d     = lastClamped;
                    pc_d       = '0;
                    stim_d     = mem[0];
                    valid_d    = 1'b1;
                    wrap_d     = '0;
                    state_d    = (mode == MODE_STEP) ? STEP_WAIT : PLAY;
                end
            end

            PLAY: begin
                if (stop) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end else if (pc_q < last_q) begin
                    pc_d   = pcNext;
                    stim_d = mem[pcNext];
                end else if (loopMode_q) begin
                    pc_d   = '0;
                    stim_d = mem[0];
                    if (wrap_q != 8'hFF) begin
                        wrap_d = wrap_q + 8'd1;
                    end
                end else begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end
            end

            STEP_WAIT: begin
                if (stop) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end else if (step) begin
                    if (pc_q < last_q) begin
                        pc_d   = pcNext;
                        stim_d = mem[pcNext];
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    assign stim       = stim_q;
    assign stim_valid = valid_q;
    assign pc         = pc_q;
    assign wrap_cnt   = wrap_q;
    assign done       = done_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_stim_player.sv
// ----------------------------------------------------------------------------
// tb_stim_player -- self-checking bench for stim_player
//
// Keeps its own copy of the pattern memory and derives every expected output
// from the playback rules with plain arithmetic (entry index = cycle count,
// modulo the pattern length in LOOP mode, pass count = cycle / length).
// Observed outputs are packed as {stim, pc, stim_valid, busy, done, wrap_cnt}.
// ----------------------------------------------------------------------------
module tb_stim_player;

    localparam int DATA_W = 2;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              start;
    logic              stop;
    logic [1:0]        mode;
    logic [AW-1:0]     last_addr;
    logic              step;
    logic [DATA_W-1:0] stim;
    logic              stim_valid;
    logic [AW-1:0]     pc;
    logic [7:0]        wrap_cnt;
    logic              done;
    logic              busy;

    logic [16:0]       obs;
    logic [DATA_W-1:0] memModel [DEPTH];
    int                testsRun    = 0;
    int                testsFailed = 0;

    assign obs = {stim, pc, stim_valid, busy, done, wrap_cnt};

    stim_player #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .last_addr  (last_addr),
        .step       (step),
        .stim       (stim),
        .stim_valid (stim_valid),
        .pc         (pc),
        .wrap_cnt   (wrap_cnt),
        .done       (done),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic writeMem(input int addr, input logic [DATA_W-1:0] data);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = data;
        tick();
        wr_en   = 1'b0;
        memModel[addr] = data;
    endtask

    task automatic loadPattern();
        writeMem(0, 2'b01);
        writeMem(1, 2'b10);
        writeMem(2, 2'b11);
        writeMem(3, 2'b00);
    endtask

    task automatic loadRandom();
        for (int a = 0; a < DEPTH; a++) begin
            writeMem(a, DATA_W'($urandom));
        end
    endtask

    // Start playback; mode/last_addr are scrambled afterwards since the
    // player must work from the values captured at start.
    task automatic startPlay(input logic [1:0] m, input int last);
        mode      = m;
        last_addr = AW'(last);
        start     = 1'b1;
        tick();
        start     = 1'b0;
        mode      = 2'($urandom);
        last_addr = AW'($urandom);
    endtask

    task automatic test_reset();
        #2;
        testsRun++;
        if (obs !== 17'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_state got %h exp %h", obs, 17'h0);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        tick();
        testsRun++;
        if (obs !== 17'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_release_idle got %h exp %h", obs, 17'h0);
        end
    endtask

    task automatic test_oneshot();
        for (int trial = 0; trial < 6; trial++) begin
            int          last;
            logic [1:0]  m;
            if (trial == 0) begin
                loadPattern();
                last = 3;
                m    = 2'b00;
            end else begin
                loadRandom();
                last = (trial == 1) ? 0 : int'($urandom_range(15, 0));
                m    = ($urandom % 2 == 0) ? 2'b00 : 2'b11;
            end
            startPlay(m, last);
            for (int k = 0; k <= last; k++) begin
                testsRun++;
                if (obs !== {memModel[k], AW'(k), 1'b1, 1'b1, 1'b0, 8'd0}) begin
                    testsFailed++;
                    $display("[TB] FAIL oneshot_play trial=%0d k=%0d got %h exp %h", trial, k,
                             obs, {memModel[k], AW'(k), 1'b1, 1'b1, 1'b0, 8'd0});
                end
                tick();
            end
            testsRun++;
            if (obs !== {memModel[last], AW'(last), 1'b0, 1'b0, 1'b1, 8'd0}) begin
                testsFailed++;
                $display("[TB] FAIL oneshot_done trial=%0d got %h exp %h", trial, obs,
                         {memModel[last], AW'(last), 1'b0, 1'b0, 1'b1, 8'd0});
            end
            tick();
            testsRun++;
            if (obs !== {memModel[last], AW'(last), 1'b0, 1'b0, 1'b0, 8'd0}) begin
                testsFailed++;
                $display("[TB] FAIL oneshot_done_once trial=%0d got %h exp %h", trial, obs,
                         {memModel[last], AW'(last), 1'b0, 1'b0, 1'b0, 8'd0});
            end
        end
    endtask

    task automatic test_loop();
        for (int trial = 0; trial < 5; trial++) begin
            int last;
            int cycles;
            int p;
            int w;
            if (trial == 0) begin
                loadPattern();
                last   = 3;
                cycles = 10;
            end else if (trial == 1) begin
                last   = 0;
                cycles = 262;
            end else begin
                loadRandom();
                last   = int'($urandom_range(7, 0));
                cycles = 3 * (last + 1) + int'($urandom_range(3, 0));
            end
            startPlay(2'b01, last);
            for (int k = 0; k < cycles; k++) begin
                p = k % (last + 1);
                w = (k / (last + 1) > 255) ? 255 : k / (last + 1);
                testsRun++;
                if (obs !== {memModel[p], AW'(p), 1'b1, 1'b1, 1'b0, 8'(w)}) begin
                    testsFailed++;
                    $display("[TB] FAIL loop_play trial=%0d k=%0d got %h exp %h", trial, k,
                             obs, {memModel[p], AW'(p), 1'b1, 1'b1, 1'b0, 8'(w)});
                end
                if (k < cycles - 1) tick();
            end
            p = (cycles - 1) % (last + 1);
            w = ((cycles - 1) / (last + 1) > 255) ? 255 : (cycles - 1) / (last + 1);
            stop = 1'b1;
            tick();
            stop = 1'b0;
            testsRun++;
            if (obs !== {memModel[p], AW'(p), 1'b0, 1'b0, 1'b0, 8'(w)}) begin
                testsFailed++;
                $display("[TB] FAIL loop_stop trial=%0d got %h exp %h", trial, obs,
                         {memModel[p], AW'(p), 1'b0, 1'b0, 1'b0, 8'(w)});
            end
        end
    endtask

    task automatic test_step();
        for (int trial = 0; trial < 4; trial++) begin
            int   last;
            int   pcExp;
            logic stepBit;
            logic finished;
            if (trial == 0) begin
                loadPattern();
                last = 3;
            end else begin
                loadRandom();
                last = int'($urandom_range(9, 0));
            end
            startPlay(2'b10, last);
            pcExp    = 0;
            finished = 1'b0;
            for (int c = 1; c < 200 && !finished; c++) begin
                if (trial == 0) stepBit = (c == 2 || c == 5 || c == 7 || c == 8);
                else            stepBit = ($urandom % 3 == 0) || (c > 150);
                step = stepBit;
                tick();
                step = 1'b0;
                if (stepBit && pcExp == last) begin
                    finished = 1'b1;
                    testsRun++;
                    if (obs !== {memModel[last], AW'(last), 1'b0, 1'b0, 1'b1, 8'd0}) begin
                        testsFailed++;
                        $display("[TB] FAIL step_done trial=%0d got %h exp %h", trial, obs,
                                 {memModel[last], AW'(last), 1'b0, 1'b0, 1'b1, 8'd0});
                    end
                end else begin
                    if (stepBit) pcExp++;
                    testsRun++;
                    if (obs !== {memModel[pcExp], AW'(pcExp), 1'b1, 1'b1, 1'b0, 8'd0}) begin
                        testsFailed++;
                        $display("[TB] FAIL step_advance trial=%0d c=%0d got %h exp %h", trial, c,
                                 obs, {memModel[pcExp], AW'(pcExp), 1'b1, 1'b1, 1'b0, 8'd0});
                    end
                end
            end
            testsRun++;
            if (!finished) begin
                testsFailed++;
                $display("[TB] FAIL step_timeout trial=%0d got busy=%b exp busy=0", trial, busy);
                stop = 1'b1;
                tick();
                stop = 1'b0;
            end
            tick();
            testsRun++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL step_idle_after trial=%0d got done=%b busy=%b exp 0 0",
                         trial, done, busy);
            end
        end
    endtask

    task automatic test_stop();
        loadPattern();
        startPlay(2'b01, 3);
        tick();
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        testsRun++;
        if (obs !== {memModel[2], AW'(2), 1'b0, 1'b0, 1'b0, 8'd0}) begin
            testsFailed++;
            $display("[TB] FAIL stop_loop got %h exp %h", obs,
                     {memModel[2], AW'(2), 1'b0, 1'b0, 1'b0, 8'd0});
        end
        mode  = 2'b01;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        tick();
        testsRun++;
        if (obs !== {memModel[2], AW'(2), 1'b0, 1'b0, 1'b0, 8'd0}) begin
            testsFailed++;
            $display("[TB] FAIL start_with_stop got %h exp %h", obs,
                     {memModel[2], AW'(2), 1'b0, 1'b0, 1'b0, 8'd0});
        end
        // stop on the final ONESHOT entry suppresses done
        startPlay(2'b00, 3);
        tick();
        tick();
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        testsRun++;
        if (obs !== {memModel[3], AW'(3), 1'b0, 1'b0, 1'b0, 8'd0}) begin
            testsFailed++;
            $display("[TB] FAIL stop_at_last got %h exp %h", obs,
                     {memModel[3], AW'(3), 1'b0, 1'b0, 1'b0, 8'd0});
        end
        tick();
        testsRun++;
        if (done !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL stop_at_last_nodone got %b exp 0", done);
        end
        // stop together with the final step
        startPlay(2'b10, 0);
        step = 1'b1;
        stop = 1'b1;
        tick();
        step = 1'b0;
        stop = 1'b0;
        testsRun++;
        if (obs !== {memModel[0], AW'(0), 1'b0, 1'b0, 1'b0, 8'd0}) begin
            testsFailed++;
            $display("[TB] FAIL stop_with_step got %h exp %h", obs,
                     {memModel[0], AW'(0), 1'b0, 1'b0, 1'b0, 8'd0});
        end
    endtask

    task automatic test_busy_start();
        loadRandom();
        startPlay(2'b00, 5);
        for (int k = 0; k <= 5; k++) begin
            testsRun++;
            if (obs !== {memModel[k], AW'(k), 1'b1, 1'b1, 1'b0, 8'd0}) begin
                testsFailed++;
                $display("[TB] FAIL busy_start k=%0d got %h exp %h", k, obs,
                         {memModel[k], AW'(k), 1'b1, 1'b1, 1'b0, 8'd0});
            end
            if (k == 2) begin
                mode      = 2'b01;
                last_addr = AW'(1);
                start     = 1'b1;
            end
            tick();
            start = 1'b0;
        end
        testsRun++;
        if (obs !== {memModel[5], AW'(5), 1'b0, 1'b0, 1'b1, 8'd0}) begin
            testsFailed++;
            $display("[TB] FAIL busy_start_done got %h exp %h", obs,
                     {memModel[5], AW'(5), 1'b0, 1'b0, 1'b1, 8'd0});
        end
        tick();
    endtask

    task automatic test_async_reset();
        loadPattern();
        startPlay(2'b01, 3);
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        testsRun++;
        if (obs !== 17'h0) begin
            testsFailed++;
            $display("[TB] FAIL async_reset got %h exp %h", obs, 17'h0);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        tick();
        tick();
        testsRun++;
        if (obs !== 17'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_no_resume got %h exp %h", obs, 17'h0);
        end
        startPlay(2'b00, 3);
        for (int k = 0; k <= 3; k++) begin
            testsRun++;
            if (obs !== {memModel[k], AW'(k), 1'b1, 1'b1, 1'b0, 8'd0}) begin
                testsFailed++;
                $display("[TB] FAIL mem_after_reset k=%0d got %h exp %h", k, obs,
                         {memModel[k], AW'(k), 1'b1, 1'b1, 1'b0, 8'd0});
            end
            tick();
        end
        tick();
    endtask

    task automatic test_read_before_write();
        logic [DATA_W-1:0] oldWord;
        logic [DATA_W-1:0] newWord;
        loadPattern();
        oldWord = memModel[1];
        newWord = ~oldWord;
        startPlay(2'b01, 3);
        wr_en   = 1'b1;
        wr_addr = AW'(1);
        wr_data = newWord;
        tick();
        wr_en   = 1'b0;
        testsRun++;
        if (obs !== {oldWord, AW'(1), 1'b1, 1'b1, 1'b0, 8'd0}) begin
            testsFailed++;
            $display("[TB] FAIL rbw_old_word got %h exp %h", obs,
                     {oldWord, AW'(1), 1'b1, 1'b1, 1'b0, 8'd0});
        end
        memModel[1] = newWord;
        for (int k = 0; k < 4; k++) tick();
        testsRun++;
        if (obs !== {newWord, AW'(1), 1'b1, 1'b1, 1'b0, 8'd1}) begin
            testsFailed++;
            $display("[TB] FAIL rbw_new_word got %h exp %h", obs,
                     {newWord, AW'(1), 1'b1, 1'b1, 1'b0, 8'd1});
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        start     = 1'b0;
        stop      = 1'b0;
        mode      = 2'b00;
        last_addr = '0;
        step      = 1'b0;
        for (int a = 0; a < DEPTH; a++) memModel[a] = '0;

        test_reset();
        test_oneshot();
        test_loop();
        test_step();
        test_stop();
        test_busy_start();
        test_async_reset();
        test_read_before_write();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/stim_player.md
STIM_PLAYER -- requirements
Module: stim_player

Interface
REQ-001 Parameter DATA_W, default 2, stimulus word width in bits.
REQ-002 Parameter DEPTH, default 16, number of pattern-memory entries; AW = clog2(DEPTH), minimum 1.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low; 0 forces the reset state immediately, release is sampled on clock.
REQ-005 wr_en  input  1  pattern-memory write strobe.
REQ-006 wr_addr  input  AW  pattern-memory write address.
REQ-007 wr_data  input  DATA_W  pattern-memory write data.
REQ-008 start  input  1  begin playback (single-cycle pulse, level tolerated).
REQ-009 stop  input  1  abort playback.
REQ-010 mode  input  2  00 ONESHOT, 01 LOOP, 10 STEP, 11 treated as ONESHOT.
REQ-011 last_addr  input  AW  index of the final pattern entry.
REQ-012 step  input  1  advance request, STEP mode only.
REQ-013 stim  output  DATA_W  current stimulus word.
REQ-014 stim_valid  output  1  stim is a played entry.
REQ-015 pc  output  AW  index of the entry currently on stim.
REQ-016 wrap_cnt  output  8  completed LOOP passes, saturating.
REQ-017 done  output  1  one-cycle pulse on normal completion.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 FSM states SHALL be IDLE, PLAY, STEP_WAIT; busy = (state != IDLE).
REQ-020 Memory write SHALL occur on any edge with wr_en=1, in any state.
REQ-021 Same-cycle write to the address being fetched: stim SHALL get the old data (read-before-write).
REQ-022 mode and last_addr SHALL be captured on the accepted start and held until IDLE; last_addr >= DEPTH clamps to DEPTH-1.
REQ-023 start in IDLE: next edge stim=mem[0], pc=0, stim_valid=1, wrap_cnt=0; state PLAY (ONESHOT/LOOP) or STEP_WAIT (STEP).
REQ-024 start while busy SHALL be ignored.
REQ-025 PLAY, pc<last: each edge pc=pc+1, stim=mem[pc+1].
REQ-026 PLAY, pc==last, ONESHOT: next edge state IDLE, stim_valid=0, done=1 for one cycle, stim and pc hold last values.
REQ-027 PLAY, pc==last, LOOP: next edge pc=0, stim=mem[0], wrap_cnt+1 saturating at 255; no done.
REQ-028 STEP_WAIT: pc/stim SHALL advance one entry per cycle with step=1; held otherwise.
REQ-029 STEP_WAIT, step=1 at pc==last: next edge IDLE, stim_valid=0, done pulse.
REQ-030 last_addr=0: ONESHOT plays one entry (stim_valid high 1 cycle); LOOP replays mem[0] every cycle, wrap_cnt+1 per cycle.
REQ-031 stop while busy: next edge IDLE, stim_valid=0, no done, pc/stim/wrap_cnt hold.
REQ-032 stop and start same cycle in IDLE: start SHALL be ignored.
REQ-033 stop coinciding with final entry: stop wins, done SHALL NOT pulse.

Reset
REQ-034 reset=0 SHALL asynchronously set state IDLE, stim=0, stim_valid=0, pc=0, wrap_cnt=0, done=0, busy=0.
REQ-035 Pattern memory contents SHALL be unaffected by reset.
REQ-036 Reset asserted mid-playback SHALL abort with no done pulse; playback resumes only on a new start.

Verification
REQ-037 Load mem[0..3]=01,10,11,00, last_addr=3, ONESHOT start -> stim 01,10,11,00 on 4 consecutive cycles with pc 0..3, then stim_valid=0, done=1 for one cycle.
REQ-038 Same load, LOOP, run 10 cycles -> sequence repeats from mem[0], wrap_cnt=2 after cycle 9.
REQ-039 STEP mode, step pulses on cycles 2 and 5 -> pc 0 held, 1 after cycle 2, 2 after cycle 5; step at pc=3 -> done pulse, IDLE.
REQ-040 LOOP running, stop at pc=2 -> next cycle stim_valid=0, busy=0, done=0, pc=2 held; start with stop same cycle -> stays IDLE.
REQ-041 reset driven low mid-edge-interval during PLAY -> all outputs zero before the next clock edge; memory re-read after fresh start matches prior load.
REQ-042 wr_en to address pc+1 while PLAY fetches it -> stim shows old word; next pass shows new word.
